// File: rtl/sdr_ecpu_pkg.sv
// Shared definitions for the CPU command/register path: header layout,
// opcodes, error bit indices and decoder state encoding.
package sdr_ecpu_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR_INC = 3'd1;
    localparam logic [2:0] OP_RD_INC = 3'd2;
    localparam logic [2:0] OP_WR_FIX = 3'd3;

    localparam int unsigned HDR_CMD_BIT = 31;
    localparam int unsigned OP_MSB      = 30;
    localparam int unsigned OP_LSB      = 28;
    localparam int unsigned LEN_MSB     = 27;
    localparam int unsigned LEN_LSB     = 20;
    localparam int unsigned ADDR_MSB    = 15;
    localparam int unsigned ADDR_LSB    = 0;

    localparam int unsigned LEN_W  = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned ADDR_W = ADDR_MSB - ADDR_LSB + 1;

    localparam int unsigned ERR_HDR  = 0;
    localparam int unsigned ERR_ADDR = 1;
    localparam int unsigned ERR_OVF  = 2;
    localparam int unsigned ERR_TMO  = 3;
    localparam int unsigned ERR_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_WR_FIX);
    endfunction

endpackage

// File: rtl/ecpu_rsp_fifo.sv
// Synchronous show-ahead FIFO for read responses; the head word is always
// presented on dout_o, and a pop frees a slot for a push in the same cycle.
module ecpu_rsp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        dout_o  = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecpu_cmd_regs.sv
// CPU command decoder: burst register writes/reads into a control register
// bank, with read data queued into a response FIFO for the return path.
module ecpu_cmd_regs
    import sdr_ecpu_pkg::*;
#(
    parameter int unsigned FT_DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT     = 16,
    parameter int unsigned RSP_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYC   = 1024,
    parameter logic [FT_DATA_WIDTH-1:0] BAD_RD_VALUE = 32'hDEADBEEF
) (
    input  logic                               clk_i,
    input  logic                               reset_n,
    input  logic [FT_DATA_WIDTH-1:0]           cpu_data_i,
    input  logic                               cpu_we_i,
    output logic [REG_COUNT*FT_DATA_WIDTH-1:0] regs_o,
    output logic [REG_COUNT-1:0]               wr_stb_o,
    output logic [FT_DATA_WIDTH-1:0]           rsp_data_o,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic                               busy_o,
    output logic [ERR_W-1:0]                   err_o,
    input  logic                               err_clr_i
);

    localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [LEN_W-1:0]         rem_q;
    logic                     inc_q;
    logic [TW-1:0]            tmo_q;
    logic                     push_q;
    logic [FT_DATA_WIDTH-1:0] push_data_q;
    logic [REG_COUNT-1:0]     wr_stb_q;
    logic [ERR_W-1:0]         err_q;
    logic [ERR_W-1:0]         err_d;
    logic [FT_DATA_WIDTH-1:0] regs_q [REG_COUNT];

    logic                     hdr_cmd;
    logic [2:0]               hdr_op;
    logic [LEN_W-1:0]         hdr_len;
    logic [ADDR_W-1:0]        hdr_addr;
    logic                     addr_in_range;
    logic [AW-1:0]            addr_idx;
    logic                     tmo_hit;
    logic [FT_DATA_WIDTH-1:0] rd_value;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ERR_W-1:0]         err_new;

    always_comb begin
        hdr_cmd       = cpu_data_i[HDR_CMD_BIT];
        hdr_op        = cpu_data_i[OP_MSB:OP_LSB];
        hdr_len       = cpu_data_i[LEN_MSB:LEN_LSB];
        hdr_addr      = cpu_data_i[ADDR_MSB:ADDR_LSB];
        addr_in_range = (addr_q < ADDR_W'(REG_COUNT));
        addr_idx      = addr_q[AW-1:0];
        rd_value      = addr_in_range ? regs_q[addr_idx] : BAD_RD_VALUE;
        tmo_hit       = (state_q != ST_IDLE) && !cpu_we_i &&
                        (tmo_q == TW'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        err_new = '0;
        if (cpu_we_i) begin
            case (state_q)
                ST_IDLE:          err_new[ERR_HDR]  = !hdr_cmd || !op_is_legal(hdr_op);
                ST_WRITE, ST_READ: err_new[ERR_ADDR] = !addr_in_range;
                default:          err_new = '0;
            endcase
        end
        err_new[ERR_TMO] = tmo_hit;
        // Full implies non-empty, so a ready pop always makes room for the push.
        err_new[ERR_OVF] = push_q && fifo_full && !rsp_ready_i;
        err_d = (err_clr_i ? '0 : err_q) | err_new;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            inc_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_stb_q    <= '0;
            err_q       <= '0;
            for (int unsigned k = 0; k < REG_COUNT; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            err_q    <= err_d;
            wr_stb_q <= '0;
            push_q   <= 1'b0;
            if (state_q == ST_IDLE) begin
                tmo_q <= '0;
                if (cpu_we_i && hdr_cmd && (hdr_len != '0)) begin
                    addr_q <= hdr_addr;
                    rem_q  <= hdr_len;
                    inc_q  <= (hdr_op == OP_WR_INC);
                    case (hdr_op)
                        OP_WR_INC, OP_WR_FIX: state_q <= ST_WRITE;
                        OP_RD_INC:            state_q <= ST_READ;
                        default:              state_q <= ST_DRAIN;
                    endcase
                end
            end else if (cpu_we_i) begin
                tmo_q <= '0;
                rem_q <= rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    state_q <= ST_IDLE;
                end
                if (state_q == ST_WRITE) begin
                    if (addr_in_range) begin
                        regs_q[addr_idx]   <= cpu_data_i;
                        wr_stb_q[addr_idx] <= 1'b1;
                    end
                    if (inc_q) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end else if (state_q == ST_READ) begin
                    push_q      <= 1'b1;
                    push_data_q <= rd_value;
                    addr_q      <= addr_q + 1'b1;
                end
            end else if (tmo_hit) begin
                state_q <= ST_IDLE;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    ecpu_rsp_fifo #(
        .WIDTH (FT_DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .push_i  (push_q),
        .din_i   (push_data_q),
        .pop_i   (rsp_ready_i),
        .dout_o  (rsp_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_regs_flat
        assign regs_o[k*FT_DATA_WIDTH +: FT_DATA_WIDTH] = regs_q[k];
    end

    assign wr_stb_o    = wr_stb_q;
    assign rsp_valid_o = !fifo_empty;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_ecpu_cmd_regs.sv
// Directed bench for ecpu_cmd_regs: burst writes/reads, range errors, FIFO
// overflow, illegal headers, timeout and asynchronous reset.
module tb_ecpu_cmd_regs;

    localparam int unsigned W   = 32;
    localparam int unsigned RC  = 16;
    localparam int unsigned RD  = 16;
    localparam int unsigned TMO = 1024;

    logic          clk_i;
    logic          reset_n;
    logic [W-1:0]  cpu_data_i;
    logic          cpu_we_i;
    logic [RC*W-1:0] regs_o;
    logic [RC-1:0] wr_stb_o;
    logic [W-1:0]  rsp_data_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          busy_o;
    logic [3:0]    err_o;
    logic          err_clr_i;

    int checks = 0;
    int errors = 0;

    ecpu_cmd_regs #(
        .FT_DATA_WIDTH (W),
        .REG_COUNT     (RC),
        .RSP_DEPTH     (RD),
        .TIMEOUT_CYC   (TMO),
        .BAD_RD_VALUE  (32'hDEADBEEF)
    ) dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .cpu_data_i  (cpu_data_i),
        .cpu_we_i    (cpu_we_i),
        .regs_o      (regs_o),
        .wr_stb_o    (wr_stb_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] hdr(input logic [2:0] op, input logic [7:0] len,
                                        input logic [15:0] addr);
        return {1'b1, op, len, 4'h0, addr};
    endfunction

    function automatic logic [31:0] fval(input int i);
        return 32'hC0DE0000 | (i * 32'h111);
    endfunction

    function automatic logic [31:0] reg_at(input int k);
        return regs_o[k*W +: W];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [31:0] w);
        cpu_data_i = w;
        cpu_we_i   = 1'b1;
        cyc();
        cpu_we_i   = 1'b0;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        cpu_data_i  = '0;
        cpu_we_i    = 1'b0;
        rsp_ready_i = 1'b0;
        err_clr_i   = 1'b0;
        repeat (2) cyc();
        check("rst_regs0",  reg_at(0), 32'h0);
        check("rst_stb",    32'(wr_stb_o), 32'h0);
        check("rst_valid",  32'(rsp_valid_o), 32'h0);
        check("rst_data",   rsp_data_o, 32'h0);
        check("rst_busy",   32'(busy_o), 32'h0);
        check("rst_err",    32'(err_o), 32'h0);
        reset_n = 1'b1;
        cyc();

        // 1: WR_INC burst to regs 2..4
        put(hdr(3'd1, 8'd3, 16'd2));
        check("t1_busy_hdr", 32'(busy_o), 32'h1);
        put(32'hAAAA0001);
        check("t1_stb_a", 32'(wr_stb_o), 32'h0004);
        check("t1_reg2",  reg_at(2), 32'hAAAA0001);
        put(32'hBBBB0002);
        check("t1_stb_b", 32'(wr_stb_o), 32'h0008);
        check("t1_reg3",  reg_at(3), 32'hBBBB0002);
        put(32'hCCCC0003);
        check("t1_stb_c", 32'(wr_stb_o), 32'h0010);
        check("t1_reg4",  reg_at(4), 32'hCCCC0003);
        check("t1_busy_end", 32'(busy_o), 32'h0);
        cyc();
        check("t1_stb_off", 32'(wr_stb_o), 32'h0);

        // 2: RD_INC burst back, streaming with ready high
        rsp_ready_i = 1'b1;
        put(hdr(3'd2, 8'd3, 16'd2));
        check("t2_valid_hdr", 32'(rsp_valid_o), 32'h0);
        put(32'h0);
        check("t2_valid_d1", 32'(rsp_valid_o), 32'h0);
        put(32'h0);
        check("t2_valid_d2", 32'(rsp_valid_o), 32'h1);
        check("t2_data_a",   rsp_data_o, 32'hAAAA0001);
        put(32'h0);
        check("t2_data_b",   rsp_data_o, 32'hBBBB0002);
        check("t2_busy_end", 32'(busy_o), 32'h0);
        cyc();
        check("t2_data_c",   rsp_data_o, 32'hCCCC0003);
        cyc();
        check("t2_empty",    32'(rsp_valid_o), 32'h0);
        rsp_ready_i = 1'b0;

        // 3: read across the top of the bank
        put(hdr(3'd3, 8'd1, 16'd15));
        put(32'h15151515);
        check("t3_reg15", reg_at(15), 32'h15151515);
        put(hdr(3'd2, 8'd2, 16'd15));
        put(32'h0);
        put(32'h0);
        check("t3_err_addr", 32'(err_o), 32'h2);
        cyc();
        check("t3_valid",  32'(rsp_valid_o), 32'h1);
        check("t3_rsp0",   rsp_data_o, 32'h15151515);
        rsp_ready_i = 1'b1;
        cyc();
        check("t3_rsp1",   rsp_data_o, 32'hDEADBEEF);
        cyc();
        check("t3_empty",  32'(rsp_valid_o), 32'h0);
        rsp_ready_i = 1'b0;
        clear_err();
        check("t3_err_clr", 32'(err_o), 32'h0);

        // 4: fill the bank with distinct values, then overflow the FIFO
        put(hdr(3'd1, 8'd16, 16'd0));
        for (int i = 0; i < 16; i++) put(fval(i));
        for (int i = 0; i < 16; i++) check($sformatf("t4_reg%0d", i), reg_at(i), fval(i));
        check("t4_err_none", 32'(err_o), 32'h0);
        put(hdr(3'd2, 8'd18, 16'd0));
        for (int i = 0; i < 18; i++) put(32'h0);
        check("t4_busy_end", 32'(busy_o), 32'h0);
        cyc();
        check("t4_err_ovf", 32'(err_o), 32'h6);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_valid%0d", i), 32'(rsp_valid_o), 32'h1);
            check($sformatf("t4_rsp%0d", i), rsp_data_o, fval(i));
            rsp_ready_i = 1'b1;
            cyc();
        end
        check("t4_drained", 32'(rsp_valid_o), 32'h0);
        rsp_ready_i = 1'b0;
        clear_err();

        // 5: non-command word and illegal opcode
        put(32'h00000005);
        check("t5_err_hdr",  32'(err_o), 32'h1);
        check("t5_busy",     32'(busy_o), 32'h0);
        clear_err();
        put(hdr(3'd7, 8'd2, 16'd3));
        check("t5_busy_ill", 32'(busy_o), 32'h1);
        check("t5_err_ill",  32'(err_o), 32'h1);
        put(32'h11111111);
        check("t5_busy_mid", 32'(busy_o), 32'h1);
        put(32'h22222222);
        check("t5_busy_end", 32'(busy_o), 32'h0);
        check("t5_stb",      32'(wr_stb_o), 32'h0);
        check("t5_reg3",     reg_at(3), fval(3));
        check("t5_valid",    32'(rsp_valid_o), 32'h0);
        clear_err();

        // 6: WR_FIX stalls mid-frame and times out
        put(hdr(3'd3, 8'd4, 16'd5));
        put(32'h55550001);
        put(32'h55550002);
        check("t6_reg5", reg_at(5), 32'h55550002);
        repeat (TMO - 1) cyc();
        check("t6_busy_pre", 32'(busy_o), 32'h1);
        check("t6_err_pre",  32'(err_o), 32'h0);
        cyc();
        check("t6_busy_tmo", 32'(busy_o), 32'h0);
        check("t6_err_tmo",  32'(err_o), 32'h8);
        put(hdr(3'd1, 8'd1, 16'd6));
        check("t6_busy_new", 32'(busy_o), 32'h1);
        put(32'h66660001);
        check("t6_reg6",     reg_at(6), 32'h66660001);
        check("t6_reg5_kept", reg_at(5), 32'h55550002);
        check("t6_busy_end", 32'(busy_o), 32'h0);

        // 7: asynchronous reset in the middle of a frame
        put(hdr(3'd1, 8'd2, 16'd0));
        put(32'h12345678);
        check("t7_reg0", reg_at(0), 32'h12345678);
        check("t7_busy", 32'(busy_o), 32'h1);
        reset_n = 1'b0;
        #2;
        check("t7_rst_reg0", reg_at(0), 32'h0);
        check("t7_rst_busy", 32'(busy_o), 32'h0);
        check("t7_rst_err",  32'(err_o), 32'h0);
        reset_n = 1'b1;
        cyc();
        check("t7_post_busy", 32'(busy_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
